matrix_entry_ctrl: RTL and testbench

Keypad-driven sequencer for the linear-regression core. Debounces key presses from the keypad decoder and assembles signed decimal numbers from digit keys. Loads them in order into the X (sample × feature) and y buffers, then launches the regression core and holds the phase until the user acknowledges the result. Sits between the keypad `Decoder` and the regression datapath; it also drives the status inputs of the OLED colour generator.

---
 rtl/lr_pkg.sv | 26 ++
 rtl/key_debounce.sv | 47 ++++
 rtl/matrix_entry_ctrl.sv | 149 ++++++++++++++
 tb/tb_matrix_entry_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/lr_pkg.sv
// rtl/lr_pkg.sv - shared constants and types for the linear-regression entry path
// Purpose: key-code constants, the entry phase enum and the default matrix
//          dimensions shared with the regression core.
// Ports:   none (package).
package lr_pkg;

   localparam int DEF_ELEM_WIDTH   = 12;
   localparam int DEF_NUM_SAMPLES  = 3;
   localparam int DEF_NUM_FEATURES = 2;

   localparam logic [3:0] KEY_NEG   = 4'hA;
   localparam logic [3:0] KEY_DONE  = 4'hD;
   localparam logic [3:0] KEY_ENTER = 4'hE;
   localparam logic [3:0] KEY_CLR   = 4'hF;

   typedef enum logic [2:0] {
      PH_IDLE    = 3'd0,
      PH_ENTRY_X = 3'd1,
      PH_ENTRY_Y = 3'd2,
      PH_FULL    = 3'd3,
      PH_START   = 3'd4,
      PH_WAIT    = 3'd5,
      PH_RESULT  = 3'd6
   } phase_e;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - level debouncer with registered rising-edge pulse
// Purpose: the debounced level follows raw once raw has differed from it for
//          STABLE_CYCLES consecutive cycles; rise_pulse marks the 0->1 update.
// Ports:   clk, rst_n (async active-low), raw (input level),
//          level (debounced level), rise_pulse (one cycle, after level rises).
module key_debounce #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise_pulse
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   logic [CW-1:0] cnt_q;
   logic          level_q;
   logic          rise_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         if (raw != level_q) begin
            // Count the current mismatching sample; the last one commits.
            if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
               level_q <= raw;
               cnt_q   <= '0;
               rise_q  <= raw;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign level      = level_q;
   assign rise_pulse = rise_q;

endmodule

// File: rtl/matrix_entry_ctrl.sv
// rtl/matrix_entry_ctrl.sv - keypad sequencer loading X/y and launching the regression core
// Purpose: debounces keys, assembles signed decimal values, fills X then y,
//          pulses core_start and holds the result until acknowledged with DONE.
// Ports:   clk, rst_n (async active-low), key_pressed/key_code (raw keypad),
//          core_done (core result pulse), ready_input_matrix, core_start,
//          X_flat/y_flat (row-major buffers), cur_value, elem_idx, phase, entry_err.
module matrix_entry_ctrl
   import lr_pkg::*;
#(
   parameter int ELEM_WIDTH    = DEF_ELEM_WIDTH,
   parameter int NUM_SAMPLES   = DEF_NUM_SAMPLES,
   parameter int NUM_FEATURES  = DEF_NUM_FEATURES,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      key_pressed,
   input  logic [3:0]                                key_code,
   input  logic                                      core_done,
   output logic                                      ready_input_matrix,
   output logic                                      core_start,
   output logic [NUM_SAMPLES*NUM_FEATURES*ELEM_WIDTH-1:0] X_flat,
   output logic [NUM_SAMPLES*ELEM_WIDTH-1:0]         y_flat,
   output logic [ELEM_WIDTH-1:0]                     cur_value,
   output logic [3:0]                                elem_idx,
   output logic [2:0]                                phase,
   output logic                                      entry_err
);

   localparam int W   = ELEM_WIDTH;
   localparam int AW  = W + 4;
   localparam int N_X = NUM_SAMPLES * NUM_FEATURES;
   localparam int N_Y = NUM_SAMPLES;
   localparam logic [3:0]    N_X4    = 4'(N_X);
   localparam logic [3:0]    N_ALL4  = 4'(N_X + N_Y);
   localparam logic [AW-1:0] MAX_MAG = AW'((2 ** (W - 1)) - 1);

   phase_e            state_q;
   logic [W-1:0]      cur_q;
   logic [3:0]        idx_q;
   logic [N_X*W-1:0]  x_q;
   logic [N_Y*W-1:0]  y_q;
   logic              err_q;

   logic key_level, key_rise, key_evt;

   key_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_debounce (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw        (key_pressed),
      .level      (key_level),
      .rise_pulse (key_rise)
   );

   assign key_evt = key_rise & key_level;

   // Digit accumulation works on the magnitude; the sign is reapplied after.
   logic [AW-1:0] cur_ext, cur_mag, next_mag;
   logic [W-1:0]  digit_val;
   logic          digit_ovf;
   logic [3:0]    idx_next;

   always_comb begin
      cur_ext   = {{4{cur_q[W-1]}}, cur_q};
      cur_mag   = cur_q[W-1] ? (AW'(0) - cur_ext) : cur_ext;
      next_mag  = cur_mag * AW'(10) + {{(AW-4){1'b0}}, key_code};
      digit_ovf = next_mag > MAX_MAG;
      digit_val = cur_q[W-1] ? (W'(0) - next_mag[W-1:0]) : next_mag[W-1:0];
      idx_next  = idx_q + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PH_IDLE;
         cur_q   <= '0;
         idx_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            PH_START: state_q <= PH_WAIT;
            PH_WAIT:  if (core_done) state_q <= PH_RESULT;
            default: ;
         endcase

         if (key_evt) begin
            case (state_q)
               PH_IDLE: state_q <= PH_ENTRY_X;
               PH_ENTRY_X, PH_ENTRY_Y: begin
                  if (key_code <= 4'd9) begin
                     if (digit_ovf) begin
                        err_q <= 1'b1;
                     end else begin
                        cur_q <= digit_val;
                        err_q <= 1'b0;
                     end
                  end else if (key_code == KEY_NEG) begin
                     cur_q <= W'(0) - cur_q;
                     err_q <= 1'b0;
                  end else if (key_code == KEY_CLR) begin
                     cur_q <= '0;
                     err_q <= 1'b0;
                  end else if (key_code == KEY_ENTER) begin
                     for (int k = 0; k < N_X; k++)
                        if (state_q == PH_ENTRY_X && idx_q == 4'(k))
                           x_q[k*W +: W] <= cur_q;
                     for (int k = 0; k < N_Y; k++)
                        if (state_q == PH_ENTRY_Y && idx_q == 4'(k + N_X))
                           y_q[k*W +: W] <= cur_q;
                     idx_q <= idx_next;
                     cur_q <= '0;
                     err_q <= 1'b0;
                     if (state_q == PH_ENTRY_X && idx_next == N_X4)
                        state_q <= PH_ENTRY_Y;
                     if (state_q == PH_ENTRY_Y && idx_next == N_ALL4)
                        state_q <= PH_FULL;
                  end else if (key_code == KEY_DONE) begin
                     err_q <= 1'b1;
                  end
               end
               PH_FULL: if (key_code == KEY_DONE) begin
                  state_q <= PH_START;
                  err_q   <= 1'b0;
               end
               PH_RESULT: if (key_code == KEY_DONE) begin
                  state_q <= PH_IDLE;
                  x_q     <= '0;
                  y_q     <= '0;
                  idx_q   <= '0;
                  cur_q   <= '0;
                  err_q   <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign ready_input_matrix = (state_q == PH_ENTRY_X) || (state_q == PH_ENTRY_Y);
   assign core_start         = (state_q == PH_START);
   assign X_flat             = x_q;
   assign y_flat             = y_q;
   assign cur_value          = cur_q;
   assign elem_idx           = idx_q;
   assign phase              = state_q;
   assign entry_err          = err_q;

endmodule

// File: tb/tb_matrix_entry_ctrl.sv
// tb/tb_matrix_entry_ctrl.sv - directed self-checking bench for matrix_entry_ctrl
module tb_matrix_entry_ctrl;

   localparam int W = 12;
   localparam int S = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          key_pressed = 1'b0;
   logic [3:0]    key_code = 4'h0;
   logic          core_done = 1'b0;
   logic          ready_input_matrix, core_start, entry_err;
   logic [6*W-1:0] X_flat;
   logic [3*W-1:0] y_flat;
   logic [W-1:0]  cur_value;
   logic [3:0]    elem_idx;
   logic [2:0]    phase;

   int checks = 0;
   int errors = 0;

   matrix_entry_ctrl #(
      .ELEM_WIDTH(W), .NUM_SAMPLES(3), .NUM_FEATURES(2), .STABLE_CYCLES(S)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_pressed(key_pressed), .key_code(key_code),
      .core_done(core_done), .ready_input_matrix(ready_input_matrix),
      .core_start(core_start), .X_flat(X_flat), .y_flat(y_flat),
      .cur_value(cur_value), .elem_idx(elem_idx), .phase(phase), .entry_err(entry_err)
   );

   always #5 clk = ~clk;

   task automatic press(input logic [3:0] code);
      @(negedge clk);
      key_code = code;
      key_pressed = 1'b1;
      repeat (6) @(negedge clk);
      key_pressed = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset;
      do_reset();
      checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got %0d expected 0", phase); end
      checks++; if ({ready_input_matrix, core_start, entry_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {ready_input_matrix, core_start, entry_err}); end
      checks++; if ({X_flat, y_flat, cur_value, elem_idx} !== '0) begin errors++; $display("FAIL reset_data got %h expected 0", {X_flat, y_flat, cur_value, elem_idx}); end
   endtask

   task automatic test_latency;
      // Wake from IDLE with a digit: it must be consumed without effect.
      @(negedge clk);
      key_code = 4'h5; key_pressed = 1'b1;
      repeat (S) @(negedge clk);
      checks++; if (phase !== 3'd0) begin errors++; $display("FAIL wake_early got %0d expected 0", phase); end
      @(negedge clk);
      checks++; if (phase !== 3'd1 || ready_input_matrix !== 1'b1) begin errors++; $display("FAIL wake_phase got %0d/%b expected 1/1", phase, ready_input_matrix); end
      checks++; if (cur_value !== 12'd0) begin errors++; $display("FAIL wake_ignored got %0d expected 0", cur_value); end
      key_pressed = 1'b0;
      repeat (6) @(negedge clk);
      // Digit 1 lands exactly S+1 edges after the first high sample.
      key_code = 4'h1; key_pressed = 1'b1;
      repeat (S) @(negedge clk);
      checks++; if (cur_value !== 12'd0) begin errors++; $display("FAIL digit_early got %0d expected 0", cur_value); end
      @(negedge clk);
      checks++; if (cur_value !== 12'd1) begin errors++; $display("FAIL digit_one got %0d expected 1", cur_value); end
      key_pressed = 1'b0;
      repeat (6) @(negedge clk);
      press(4'h2);
      checks++; if (cur_value !== 12'd12) begin errors++; $display("FAIL digit_two got %0d expected 12", cur_value); end
      press(4'hE);
      checks++; if (X_flat[11:0] !== 12'd12 || elem_idx !== 4'd1 || cur_value !== 12'd0) begin errors++; $display("FAIL enter_x0 got %0d/%0d/%0d expected 12/1/0", X_flat[11:0], elem_idx, cur_value); end
   endtask

   task automatic test_glitch;
      @(negedge clk);
      key_code = 4'h7; key_pressed = 1'b1;
      repeat (3) @(negedge clk);
      key_pressed = 1'b0;
      @(negedge clk);
      key_pressed = 1'b1;
      repeat (3) @(negedge clk);
      key_pressed = 1'b0;
      repeat (8) @(negedge clk);
      checks++; if (cur_value !== 12'd0 || phase !== 3'd1 || elem_idx !== 4'd1) begin errors++; $display("FAIL glitch got %0d/%0d/%0d expected 0/1/1", cur_value, phase, elem_idx); end
   endtask

   task automatic test_overflow;
      press(4'h2); press(4'h0); press(4'h4);
      checks++; if (cur_value !== 12'd204 || entry_err !== 1'b0) begin errors++; $display("FAIL accum got %0d/%b expected 204/0", cur_value, entry_err); end
      press(4'h8);
      checks++; if (cur_value !== 12'd204 || entry_err !== 1'b1) begin errors++; $display("FAIL overflow got %0d/%b expected 204/1", cur_value, entry_err); end
      press(4'hA);
      checks++; if (cur_value !== 12'hF34 || entry_err !== 1'b0) begin errors++; $display("FAIL negate got %h/%b expected f34/0", cur_value, entry_err); end
      press(4'hE);
      checks++; if (X_flat[23:12] !== 12'hF34 || elem_idx !== 4'd2) begin errors++; $display("FAIL enter_neg got %h/%0d expected f34/2", X_flat[23:12], elem_idx); end
   endtask

   task automatic test_done_err;
      press(4'hE);
      checks++; if (X_flat[35:0] !== {12'h000, 12'hF34, 12'h00C} || elem_idx !== 4'd3) begin errors++; $display("FAIL enter_empty got %h/%0d expected 000f3400c/3", X_flat[35:0], elem_idx); end
      press(4'hD);
      checks++; if (phase !== 3'd1 || entry_err !== 1'b1 || elem_idx !== 4'd3) begin errors++; $display("FAIL done_early got %0d/%b/%0d expected 1/1/3", phase, entry_err, elem_idx); end
      press(4'h7);
      checks++; if (entry_err !== 1'b0 || cur_value !== 12'd7) begin errors++; $display("FAIL err_clear got %b/%0d expected 0/7", entry_err, cur_value); end
      press(4'hF);
      checks++; if (cur_value !== 12'd0) begin errors++; $display("FAIL clear got %0d expected 0", cur_value); end
   endtask

   task automatic test_fill_and_run;
      logic [6*W-1:0] exp_x;
      logic [3*W-1:0] exp_y;
      int starts = 0;
      bit saw_start = 1'b0;
      for (int k = 0; k < 6; k++) exp_x[k*W +: W] = 12'(k + 1);
      for (int k = 0; k < 3; k++) exp_y[k*W +: W] = 12'(k + 7);
      do_reset();
      press(4'h0);
      for (int v = 1; v <= 6; v++) begin press(4'(v)); press(4'hE); end
      checks++; if (phase !== 3'd2 || ready_input_matrix !== 1'b1 || elem_idx !== 4'd6) begin errors++; $display("FAIL to_entry_y got %0d/%b/%0d expected 2/1/6", phase, ready_input_matrix, elem_idx); end
      for (int v = 7; v <= 9; v++) begin press(4'(v)); press(4'hE); end
      checks++; if (phase !== 3'd3 || ready_input_matrix !== 1'b0) begin errors++; $display("FAIL to_full got %0d/%b expected 3/0", phase, ready_input_matrix); end
      checks++; if (X_flat !== exp_x) begin errors++; $display("FAIL x_flat got %h expected %h", X_flat, exp_x); end
      checks++; if (y_flat !== exp_y) begin errors++; $display("FAIL y_flat got %h expected %h", y_flat, exp_y); end
      press(4'h5);
      @(negedge clk); core_done = 1'b1;
      @(negedge clk); core_done = 1'b0;
      checks++; if (phase !== 3'd3 || cur_value !== 12'd0 || X_flat !== exp_x || entry_err !== 1'b0) begin errors++; $display("FAIL full_ignore got %0d/%0d/%b expected 3/0/0", phase, cur_value, entry_err); end
      // DONE launches the core; a core_done coinciding with START is dropped.
      @(negedge clk);
      key_code = 4'hD; key_pressed = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 5) key_pressed = 1'b0;
         core_done = 1'b0;
         if (core_start) starts++;
         if (phase == 3'd4) begin core_done = 1'b1; saw_start = 1'b1; end
      end
      core_done = 1'b0;
      checks++; if (!saw_start || starts != 1) begin errors++; $display("FAIL start_pulse got %0d cycles expected 1", starts); end
      checks++; if (phase !== 3'd5) begin errors++; $display("FAIL to_wait got %0d expected 5", phase); end
      @(negedge clk); core_done = 1'b1;
      @(negedge clk); core_done = 1'b0;
      checks++; if (phase !== 3'd6 || X_flat !== exp_x || y_flat !== exp_y) begin errors++; $display("FAIL to_result got %0d expected 6 with buffers held", phase); end
      press(4'hD);
      checks++; if (phase !== 3'd0 || {X_flat, y_flat, cur_value, elem_idx} !== '0) begin errors++; $display("FAIL ack_idle got %0d/%h expected 0/0", phase, {X_flat, y_flat, elem_idx}); end
   endtask

   task automatic test_reset_mid;
      press(4'h0);
      press(4'h3); press(4'hE);
      for (int i = 0; i < 5; i++) press(4'hE);
      press(4'h4);
      checks++; if (phase !== 3'd2 || cur_value !== 12'd4 || X_flat[11:0] !== 12'd3) begin errors++; $display("FAIL pre_reset got %0d/%0d expected 2/4", phase, cur_value); end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (phase !== 3'd0 || {ready_input_matrix, core_start, entry_err} !== 3'b000 || {X_flat, y_flat, cur_value, elem_idx} !== '0) begin errors++; $display("FAIL async_reset got %0d/%h expected 0/0", phase, {X_flat, cur_value, elem_idx}); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_overflow();
      test_done_err();
      test_fill_and_run();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
